// File: rtl/trace_streamer_pkg.sv
// Shared types and sizes for the trace streamer: FSM states, beat tags, frame geometry.
// With TRACE_HDR_EN defined the header state exists; otherwise frames start at the PC beat.
package trace_pkg;

    localparam int NUM_REGS      = 32;
    localparam int NUM_MEM_WORDS = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
`ifdef TRACE_HDR_EN
        ST_HDR  = 3'd1,
`endif
        ST_PC   = 3'd2,
        ST_REG  = 3'd3,
        ST_MEM  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TAG_HDR = 2'd0,
        TAG_PC  = 2'd1,
        TAG_REG = 2'd2,
        TAG_MEM = 2'd3
    } tag_e;

endpackage

// File: rtl/trace_streamer_if.sv
// Valid/ready trace beat stream: 32-bit data, 2-bit tag, end-of-frame marker.
interface trace_streamer_if;
    import trace_pkg::*;

    logic        valid;
    logic        ready;
    logic [31:0] data;
    tag_e        tag;
    logic        last;

    modport master (output valid, data, tag, last, input ready);
    modport slave  (input valid, data, tag, last, output ready);
endinterface

// File: rtl/trace_streamer_sat_counter.sv
// Up-counter with selectable saturate-at-max or wrap-to-zero behaviour.
// Latency: count visible the cycle after inc_i. No backpressure.
module trace_sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(SATURATE && (cnt_q == {WIDTH{1'b1}})))
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/trace_streamer.sv
// Dumps CPU state (optional header, PC, 32 regs, 8 memory words) as a tagged beat stream; TRACE_HDR_EN adds header.
// Latency: first beat valid the cycle after an accepted trigger. Backpressure: beat held until ready; CPU stalled all frame.
module trace_streamer
    import trace_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               trig_i,
    input  logic [31:0]        pc_i,
    output logic [4:0]         reg_addr_o,
    input  logic [31:0]        reg_data_i,
    output logic [4:0]         dmem_addr_o,
    input  logic [31:0]        dmem_data_i,
    output logic               stall_o,
    output logic [15:0]        drop_cnt_o,
    trace_streamer_if.master   trace_o
);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] pc_q, pc_d;

    logic accept;
    logic start_frame;
    logic drop;
    logic frame_done;

    assign accept      = trace_o.valid && trace_o.ready;
    assign start_frame = (state_q == ST_IDLE) && trig_i && start_i;
    // A trigger while busy is lost, including the cycle the final beat leaves.
    assign drop        = (state_q != ST_IDLE) && trig_i && start_i;
    assign frame_done  = accept && (state_q == ST_MEM) && (idx_q == 5'(NUM_MEM_WORDS - 1));

`ifdef TRACE_HDR_EN
    logic [31:0] frame_cnt;

    trace_sat_counter #(.WIDTH(32), .SATURATE(1'b0)) u_frame_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (frame_done),
        .cnt_o (frame_cnt)
    );
`endif

    trace_sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_drop_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (drop),
        .cnt_o (drop_cnt_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pc_d          = pc_q;
        trace_o.valid = 1'b0;
        trace_o.data  = '0;
        trace_o.tag   = TAG_HDR;
        trace_o.last  = 1'b0;
        reg_addr_o    = '0;
        dmem_addr_o   = '0;
        stall_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    pc_d  = pc_i;
                    idx_d = '0;
`ifdef TRACE_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_PC;
`endif
                end
            end
`ifdef TRACE_HDR_EN
            ST_HDR: begin
                trace_o.valid = 1'b1;
                stall_o       = 1'b1;
                trace_o.tag   = TAG_HDR;
                trace_o.data  = frame_cnt;
                if (accept) state_d = ST_PC;
            end
`endif
            ST_PC: begin
                trace_o.valid = 1'b1;
                stall_o       = 1'b1;
                trace_o.tag   = TAG_PC;
                trace_o.data  = pc_q;
                if (accept) begin
                    state_d = ST_REG;
                    idx_d   = '0;
                end
            end
            ST_REG: begin
                trace_o.valid = 1'b1;
                stall_o       = 1'b1;
                trace_o.tag   = TAG_REG;
                reg_addr_o    = idx_q;
                trace_o.data  = reg_data_i;
                if (accept) begin
                    if (idx_q == 5'(NUM_REGS - 1)) begin
                        state_d = ST_MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_MEM: begin
                trace_o.valid = 1'b1;
                stall_o       = 1'b1;
                trace_o.tag   = TAG_MEM;
                dmem_addr_o   = {idx_q[2:0], 2'b00};
                trace_o.data  = dmem_data_i;
                trace_o.last  = (idx_q == 5'(NUM_MEM_WORDS - 1));
                if (accept) begin
                    if (frame_done) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
